ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/move ops with a registered result, plus an
// iterative shift-add MULT/MULTU unit (RADIX_BITS bits per cycle) writing HI/LO.
module ex_stage #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic        stall_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_SRAV  = 8'b0000_0111;
  localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;

  localparam int N  = 32 / RADIX_BITS;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_hi, r_lo;
  logic [63:0]     r_mcand, r_acc;
  logic [32:0]     r_mplr;
  logic            r_neg;
  logic [4:0]      r_wd;
  logic            r_wreg;
  logic [31:0]     r_wdata;

  logic            w_accept, w_known, w_wreg, w_is_mul, w_signed, w_neg;
  logic [4:0]      w_sh;
  logic [31:0]     w_logic, w_shift, w_move, w_res;
  logic [32:0]     w_a_ext, w_b_ext, w_a_mag, w_b_mag;
  logic [63:0]     w_part, w_sum, w_prod;

  assign w_accept = (r_state == IDLE) && id_valid_i && !flush_i;
  assign w_sh     = reg1_i[4:0];

  always_comb begin
    w_known  = 1'b1;
    w_wreg   = wreg_i;
    w_logic  = '0;
    w_shift  = '0;
    w_move   = '0;
    w_is_mul = 1'b0;
    w_signed = 1'b0;
    case (aluop_i)
      OP_OR:            w_logic = reg1_i | reg2_i;
      OP_AND:           w_logic = reg1_i & reg2_i;
      OP_XOR:           w_logic = reg1_i ^ reg2_i;
      OP_NOR:           w_logic = ~(reg1_i | reg2_i);
      OP_SLL:           w_shift = reg2_i << w_sh;
      OP_SRL:           w_shift = reg2_i >> w_sh;
      OP_SRA, OP_SRAV:  w_shift = 32'($signed(reg2_i) >>> w_sh);
      OP_MOVZ: begin
        w_move = reg1_i;
        w_wreg = wreg_i & ~(|reg2_i);
      end
      OP_MOVN: begin
        w_move = reg1_i;
        w_wreg = wreg_i & (|reg2_i);
      end
      OP_MFHI:          w_move = r_hi;
      OP_MFLO:          w_move = r_lo;
      OP_MTHI, OP_MTLO: w_wreg = 1'b0;
      OP_MULT: begin
        w_wreg   = 1'b0;
        w_is_mul = 1'b1;
        w_signed = 1'b1;
      end
      OP_MULTU: begin
        w_wreg   = 1'b0;
        w_is_mul = 1'b1;
      end
      default: begin
        w_known = 1'b0;
        w_wreg  = 1'b0;
      end
    endcase
    case (alusel_i)
      SEL_LOGIC: w_res = w_logic;
      SEL_SHIFT: w_res = w_shift;
      SEL_MOVE:  w_res = w_move;
      default:   w_res = '0;
    endcase
  end

  // 33-bit magnitudes so that |0x80000000| is representable for signed MULT.
  assign w_a_ext = {w_signed & reg1_i[31], reg1_i};
  assign w_b_ext = {w_signed & reg2_i[31], reg2_i};
  assign w_a_mag = w_a_ext[32] ? (~w_a_ext + 33'd1) : w_a_ext;
  assign w_b_mag = w_b_ext[32] ? (~w_b_ext + 33'd1) : w_b_ext;
  assign w_neg   = w_signed & (reg1_i[31] ^ reg2_i[31]);

  always_comb begin
    w_part = '0;
    for (int b = 0; b < RADIX_BITS; b++)
      if (r_mplr[b]) w_part = w_part + (r_mcand << b);
  end

  assign w_sum  = r_acc + w_part;
  assign w_prod = r_neg ? (~w_sum + 64'd1) : w_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_neg   <= 1'b0;
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept && w_known) begin
            r_wd    <= wd_i;
            r_wreg  <= w_wreg;
            r_wdata <= w_res;
            if (aluop_i == OP_MTHI) r_hi <= reg1_i;
            if (aluop_i == OP_MTLO) r_lo <= reg1_i;
            if (w_is_mul) begin
              r_state <= MUL;
              r_cnt   <= '0;
              r_acc   <= '0;
              r_mcand <= {31'b0, w_a_mag};
              r_mplr  <= w_b_mag;
              r_neg   <= w_neg;
            end
          end
        end
        MUL: begin
          if (flush_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LAST) begin
            {r_hi, r_lo} <= w_prod;
            r_state      <= IDLE;
            r_cnt        <= '0;
          end else begin
            r_acc   <= w_sum;
            r_mcand <= r_mcand << RADIX_BITS;
            r_mplr  <= r_mplr >> RADIX_BITS;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall_o = (r_state == MUL);
  assign wd_o    = r_wd;
  assign wreg_o  = r_wreg;
  assign wdata_o = r_wdata;
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;

endmodule
